// File: rtl/mem_responder.sv
// Memory-side responder for the CPU mem_cmd bus: latches a command, inserts
// WAIT_CYCLES wait states, then performs one access to a word-addressed RAM.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] CMD_RD  = 2'd0;
  localparam logic [1:0] CMD_NO  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_ILL = 2'd3;

  localparam int              RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [1:0]          r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_open, w_cmd_ok, w_same, w_accept, w_illegal, w_in_range;
  logic [RAM_AW-1:0]   w_idx;

  assign w_open     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_cmd_ok   = (mem_cmd == CMD_RD) || (mem_cmd == CMD_WR);
  assign w_same     = (mem_cmd == r_cmd) && (mem_addr == r_addr);
  // In DONE a held command must not re-trigger; only a new cmd/addr pair is accepted.
  assign w_accept   = w_cmd_ok && ((r_state == S_IDLE) || ((r_state == S_DONE) && !w_same));
  assign w_illegal  = w_open && (mem_cmd == CMD_ILL);
  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[RAM_AW-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: w_next = S_DONE;
      S_DONE: begin
        if (w_accept)              w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        else if (mem_cmd == CMD_NO) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (r_state == S_RESP);
      r_busy  <= (w_next == S_WAIT) || (w_next == S_RESP);
      if (w_accept) begin
        r_cmd   <= mem_cmd;
        r_addr  <= mem_addr;
        r_wdata <= write_data;
        r_cnt   <= WAIT_LD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_illegal) r_err <= 1'b1;
      if (r_state == S_RESP) begin
        if (!w_in_range) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else if (r_cmd == CMD_RD) begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // RAM is written only from RESP, so a reset during WAIT drops the pending store.
  always_ff @(posedge clk) begin
    if ((r_state == S_RESP) && (r_cmd == CMD_WR) && w_in_range)
      r_mem[w_idx] <= r_wdata;
  end

  assign read_data = r_rdata;
  assign mem_ready = r_ready;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: dut_a uses one wait state, dut_b none.
module tb_mem_responder;
  localparam logic [1:0] RD = 2'd0, NO = 2'd1, WR = 2'd2, ILL = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cmd_a, cmd_b;
  logic [8:0]  addr_a, addr_b;
  logic [15:0] wd_a, wd_b;
  logic [15:0] rd_a, rd_b;
  logic        rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;

  mem_responder #(.ADDR_W(9), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst_n), .mem_cmd(cmd_a), .mem_addr(addr_a), .write_data(wd_a),
    .read_data(rd_a), .mem_ready(rdy_a), .busy(busy_a), .err(err_a));

  mem_responder #(.ADDR_W(9), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst_n), .mem_cmd(cmd_b), .mem_addr(addr_b), .write_data(wd_b),
    .read_data(rd_b), .mem_ready(rdy_b), .busy(busy_b), .err(err_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          rdy_cyc;
    logic        chk;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rdy_a === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_ready: got mem_ready=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        check("a_ready_cycle", cyc, e.rdy_cyc);
        if (e.chk) check("a_read_data", rd_a, e.data);
        check("a_err", err_a, e.err);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rdy_b === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_ready: got mem_ready=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        check("b_ready_cycle", cyc, e.rdy_cyc);
        if (e.chk) check("b_read_data", rd_b, e.data);
        check("b_err", err_b, e.err);
      end
    end
  end

  // Called at a negedge with the DUT in IDLE or DONE; response due WAIT+2 edges later.
  task automatic op(input bit b, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                    input bit push, input bit chk, input logic [15:0] ed, input logic ee,
                    input int hold);
    exp_t e;
    e.rdy_cyc = cyc + (b ? 0 : 1) + 2;
    e.chk     = chk;
    e.data    = ed;
    e.err     = ee;
    if (b) begin
      cmd_b = c; addr_b = a; wd_b = d;
      if (push) q_b.push_back(e);
    end else begin
      cmd_a = c; addr_a = a; wd_a = d;
      if (push) q_a.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic idle(input bit b, input int n);
    if (b) cmd_b = NO; else cmd_a = NO;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    op(0, WR, a, d, 1, 0, 16'h0, 0, 3);
    idle(0, 1);
  endtask

  initial begin
    int nb;
    rst_n = 1'b0;
    cmd_a = NO; addr_a = '0; wd_a = '0;
    cmd_b = NO; addr_b = '0; wd_b = '0;
    repeat (2) @(negedge clk);
    check("rst_read_data", rd_a, 0);
    check("rst_ready", rdy_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_err_b", err_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // write then read back
    wr(9'd5, 16'hBEEF);
    op(0, RD, 9'd5, 16'h0, 1, 1, 16'hBEEF, 0, 3);
    idle(0, 1);
    check("a_err_after_rw", err_a, 0);

    wr(9'd3, 16'h0303);
    wr(9'd7, 16'h7777);
    wr(9'd8, 16'h8888);
    wr(9'd44, 16'h4444);
    wr(9'd2, 16'h2222);

    // held read: single response, busy for WAIT+1 cycles
    op(0, RD, 9'd3, 16'h0, 1, 1, 16'h0303, 0, 0);
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy_a) nb++;
    end
    check("a_busy_cycles", nb, 2);
    idle(0, 1);

    // back-to-back reads without MNONE
    op(0, RD, 9'd7, 16'h0, 1, 1, 16'h7777, 0, 3);
    op(0, RD, 9'd8, 16'h0, 1, 1, 16'h8888, 0, 3);
    idle(0, 1);

    // out-of-range write: err sticky, aliased word untouched
    op(0, WR, 9'd300, 16'h1234, 1, 0, 16'h0, 1, 3);
    idle(0, 3);
    check("a_err_sticky", err_a, 1);
    op(0, RD, 9'd44, 16'h0, 1, 1, 16'h4444, 1, 3);
    idle(0, 1);

    // zero wait states: latency 1
    op(1, WR, 9'd10, 16'h5A5A, 1, 0, 16'h0, 0, 2);
    idle(1, 1);
    op(1, RD, 9'd10, 16'h0, 1, 1, 16'h5A5A, 0, 2);
    idle(1, 1);
    check("b_err_before_ill", err_b, 0);

    // illegal command: err, no accept
    op(1, ILL, 9'd0, 16'h0, 0, 0, 16'h0, 0, 3);
    check("b_err_illegal", err_b, 1);
    check("b_busy_illegal", busy_b, 0);
    idle(1, 1);

    // reset during WAIT of a write
    op(0, WR, 9'd2, 16'hAAAA, 0, 0, 16'h0, 0, 1);
    check("a_busy_in_wait", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("arst_read_data", rd_a, 0);
    check("arst_ready", rdy_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_err", err_a, 0);
    cmd_a = NO;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, RD, 9'd2, 16'h0, 1, 1, 16'h2222, 0, 3);
    idle(0, 2);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
